sd_block_reader: RTL and testbench

- Single-block SD read engine (CMD17) in SPI mode. It sits downstream of SD card power-up/initialisation.
- Enabled once init reports ready. Uses the init stage's is_sdhc flag to choose block or byte addressing.
- Drives the shared spi_master_byte byte engine at the fast divider. Streams the 512 data bytes of one sector to the image-processing datapath.
- Top-level muxes SPI engine inputs and sd_cs_n: init stage owns them while init_ready=0, this block owns them while init_ready=1.

---
 rtl/sd_pkg.sv | 34 +++
 rtl/sd_block_reader_if.sv | 21 ++
 rtl/sd_cmd_sender.sv | 91 +++++++++
 rtl/sd_block_reader.sv | 193 +++++++++++++++++++
 tb/tb_sd_block_reader.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared SD-card SPI-mode constants, error codes and reader states.
// Also holds the CMD17 argument builder used by the block readers.
package sd_pkg;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] CMD17_CRC   = 8'h01;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] BYTE_IDLE   = 8'hFF;
  localparam logic [7:0] R1_READY    = 8'h00;

  typedef enum logic [1:0] {
    ErrNone      = 2'b00,
    ErrR1Timeout = 2'b01,
    ErrR1Bad     = 2'b10,
    ErrToken     = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StR1,
    StToken,
    StData,
    StCrc,
    StTail,
    StErr
  } rd_state_e;

  // SDSC cards take a byte address, SDHC/SDXC take the sector number directly.
  function automatic logic [31:0] sd_arg(input logic is_sdhc, input logic [31:0] lba);
    return is_sdhc ? lba : {lba[22:0], 9'd0};
  endfunction

endpackage

// File: rtl/sd_block_reader_if.sv
// Connection to the shared spi_master_byte engine.
interface sd_block_reader_if;

  logic [15:0] spi_div;
  logic        spi_start;
  logic [7:0]  spi_mosi;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_miso;

  modport master (
    output spi_div, spi_start, spi_mosi,
    input  spi_busy, spi_done, spi_miso
  );

  modport slave (
    input  spi_div, spi_start, spi_mosi,
    output spi_busy, spi_done, spi_miso
  );

endinterface

// File: rtl/sd_cmd_sender.sv
// 6-byte SD command serializer plus single-byte issue logic for the SPI byte engine.
// Guarantees exactly one engine start per byte, even when the engine raises busy late.
module sd_cmd_sender
  import sd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_start_i,
  input  logic [7:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [7:0]  cmd_crc_i,
  output logic        cmd_done_o,
  input  logic        byte_req_i,
  input  logic [7:0]  byte_val_i,
  output logic        byte_done_o,
  output logic [7:0]  byte_miso_o,
  output logic        spi_start_o,
  output logic [7:0]  spi_mosi_o,
  input  logic        spi_busy_i,
  input  logic        spi_done_i,
  input  logic [7:0]  spi_miso_i
);

  logic        cmd_active_q, cmd_active_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] frame_q, frame_d;
  logic        in_flight_q, in_flight_d;
  logic        done_seen;

  assign byte_miso_o = spi_miso_i;

  always_comb begin
    cmd_active_d = cmd_active_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    in_flight_d  = in_flight_q;
    cmd_done_o   = 1'b0;
    byte_done_o  = 1'b0;
    // A done with nothing in flight is a leftover from before a reset.
    done_seen    = spi_done_i & in_flight_q;

    spi_start_o = (cmd_active_q | byte_req_i) & ~spi_busy_i & ~spi_done_i & ~in_flight_q;
    if (cmd_active_q) begin
      spi_mosi_o = frame_q[47:40];
    end else if (byte_req_i) begin
      spi_mosi_o = byte_val_i;
    end else begin
      spi_mosi_o = BYTE_IDLE;
    end

    if (cmd_start_i) begin
      cmd_active_d = 1'b1;
      idx_d        = 3'd0;
      frame_d      = {cmd_idx_i, cmd_arg_i, cmd_crc_i};
    end

    if (spi_start_o) begin
      in_flight_d = 1'b1;
    end

    if (done_seen) begin
      in_flight_d = 1'b0;
      if (cmd_active_q) begin
        frame_d = {frame_q[39:0], BYTE_IDLE};
        if (idx_q == 3'd5) begin
          cmd_active_d = 1'b0;
          cmd_done_o   = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        byte_done_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_active_q <= 1'b0;
      idx_q        <= 3'd0;
      frame_q      <= 48'd0;
      in_flight_q  <= 1'b0;
    end else begin
      cmd_active_q <= cmd_active_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      in_flight_q  <= in_flight_d;
    end
  end

endmodule

// File: rtl/sd_block_reader.sv
// Single-sector CMD17 read engine for an SD card in SPI mode.
// Streams the 512 data bytes out as one-cycle dout_valid pulses.
module sd_block_reader
  import sd_pkg::*;
#(
  parameter logic [15:0] FAST_DIV       = 16'd2,
  parameter logic [7:0]  R1_POLL_MAX    = 8'd16,
  parameter logic [15:0] TOKEN_POLL_MAX = 16'd50000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_ready_i,
  input  logic               is_sdhc_i,
  input  logic               rd_start_i,
  input  logic [31:0]        rd_addr_i,
  output logic               rd_busy_o,
  output logic               rd_done_o,
  output logic               rd_err_o,
  output logic [1:0]         err_code_o,
  output logic [7:0]         dout_o,
  output logic               dout_valid_o,
  output logic               dout_last_o,
  sd_block_reader_if.master  spi_io,
  output logic               sd_cs_n_o
);

  rd_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  err_code_e   err_code_q, err_code_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        cmd_start;
  logic        cmd_done;
  logic        byte_req;
  logic        byte_done;
  logic [7:0]  miso;

  assign spi_io.spi_div = FAST_DIV;
  assign rd_busy_o      = (state_q != StIdle);
  assign sd_cs_n_o      = (state_q == StIdle) | (state_q == StTail) | (state_q == StErr);
  assign rd_done_o      = done_q;
  assign rd_err_o       = err_q;
  assign err_code_o     = err_code_q;
  assign dout_o         = dout_q;
  assign dout_valid_o   = valid_q;
  assign dout_last_o    = last_q;

  sd_cmd_sender u_cmd_sender (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_start_i (cmd_start),
    .cmd_idx_i   (CMD17),
    .cmd_arg_i   (sd_arg(is_sdhc_i, rd_addr_i)),
    .cmd_crc_i   (CMD17_CRC),
    .cmd_done_o  (cmd_done),
    .byte_req_i  (byte_req),
    .byte_val_i  (BYTE_IDLE),
    .byte_done_o (byte_done),
    .byte_miso_o (miso),
    .spi_start_o (spi_io.spi_start),
    .spi_mosi_o  (spi_io.spi_mosi),
    .spi_busy_i  (spi_io.spi_busy),
    .spi_done_i  (spi_io.spi_done),
    .spi_miso_i  (spi_io.spi_miso)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cmd_start  = 1'b0;
    byte_req   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rd_start_i && init_ready_i) begin
          cmd_start  = 1'b1;
          err_code_d = ErrNone;
          state_d    = StCmd;
        end
      end
      StCmd: begin
        if (cmd_done) begin
          cnt_d   = 16'd0;
          state_d = StR1;
        end
      end
      StR1: begin
        byte_req = 1'b1;
        if (byte_done) begin
          if (miso == R1_READY) begin
            cnt_d   = 16'd0;
            state_d = StToken;
          end else if (miso != BYTE_IDLE) begin
            err_code_d = ErrR1Bad;
            state_d    = StErr;
          end else if (cnt_q + 16'd1 == {8'd0, R1_POLL_MAX}) begin
            err_code_d = ErrR1Timeout;
            state_d    = StErr;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StToken: begin
        byte_req = 1'b1;
        if (byte_done) begin
          if (miso == TOKEN_START) begin
            cnt_d   = 16'd0;
            state_d = StData;
          end else if ((miso[7:4] == 4'h0) || (cnt_q + 16'd1 == TOKEN_POLL_MAX)) begin
            // Upper nibble zero is a data error token from the card.
            err_code_d = ErrToken;
            state_d    = StErr;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StData: begin
        byte_req = 1'b1;
        if (byte_done) begin
          dout_d  = miso;
          valid_d = 1'b1;
          if (cnt_q[8:0] == 9'd511) begin
            last_d  = 1'b1;
            cnt_d   = 16'd0;
            state_d = StCrc;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StCrc: begin
        byte_req = 1'b1;
        if (byte_done) begin
          if (cnt_q[0]) begin
            state_d = StTail;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StTail: begin
        byte_req = 1'b1;
        if (byte_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StErr: begin
        byte_req = 1'b1;
        if (byte_done) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      err_code_q <= ErrNone;
      dout_q     <= 8'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: byte-engine model with late busy, scripted card responses,
// and a dout scoreboard filled when each read is launched.
module tb_sd_block_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_ready = 1'b0;
  logic        is_sdhc = 1'b1;
  logic        rd_start = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic        rd_busy, rd_done, rd_err, dout_valid, dout_last, sd_cs_n;
  logic [1:0]  err_code;
  logic [7:0]  dout;

  sd_block_reader_if spi_bus ();

  sd_block_reader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .init_ready_i (init_ready),
    .is_sdhc_i    (is_sdhc),
    .rd_start_i   (rd_start),
    .rd_addr_i    (rd_addr),
    .rd_busy_o    (rd_busy),
    .rd_done_o    (rd_done),
    .rd_err_o     (rd_err),
    .err_code_o   (err_code),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_last_o  (dout_last),
    .spi_io       (spi_bus),
    .sd_cs_n_o    (sd_cs_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Card script: R1 after sc_r1_delay 0xFF polls, token after sc_tok_delay more, then data i%256.
  int         sc_r1_delay = 0;
  logic [7:0] sc_r1_val   = 8'h00;
  int         sc_tok_delay = 0;
  logic [7:0] sc_tok_val  = 8'hFE;

  function automatic logic [7:0] card_byte(input int k);
    int b;
    int i;
    if (k < 6) return 8'hFF;
    b = 6 + sc_r1_delay;
    if (k < b) return 8'hFF;
    if (k == b) return sc_r1_val;
    b = b + 1 + sc_tok_delay;
    if (k < b) return 8'hFF;
    if (k == b) return sc_tok_val;
    i = k - b - 1;
    if (i < 512) return 8'(i % 256);
    return 8'hFF;
  endfunction

  // Byte engine model: busy rises one cycle after start, done three cycles later.
  int         eng_cnt = 0;
  int         card_k = 0;
  int         n_starts = 0;
  int         dbl_starts = 0;
  logic [7:0] mosi_arr [1024];

  always @(posedge clk) begin
    if (rst) begin
      eng_cnt          <= 0;
      spi_bus.spi_busy <= 1'b0;
      spi_bus.spi_done <= 1'b0;
      spi_bus.spi_miso <= 8'hFF;
    end else begin
      spi_bus.spi_done <= 1'b0;
      if (rd_start && init_ready && !rd_busy) begin
        card_k   <= 0;
        n_starts <= 0;
      end
      if (spi_bus.spi_start) begin
        if (eng_cnt != 0 || spi_bus.spi_busy || spi_bus.spi_done) dbl_starts <= dbl_starts + 1;
        mosi_arr[n_starts % 1024] <= spi_bus.spi_mosi;
        n_starts <= n_starts + 1;
        eng_cnt  <= 1;
      end else if (eng_cnt == 1) begin
        spi_bus.spi_busy <= 1'b1;
        eng_cnt          <= 2;
      end else if (eng_cnt == 2 || eng_cnt == 3) begin
        eng_cnt <= eng_cnt + 1;
      end else if (eng_cnt == 4) begin
        spi_bus.spi_busy <= 1'b0;
        spi_bus.spi_done <= 1'b1;
        spi_bus.spi_miso <= card_byte(card_k);
        card_k           <= card_k + 1;
        eng_cnt          <= 0;
      end
    end
  end

  logic [7:0] exp_q [$];

  // Results of the most recent do_read.
  int         r_valid, r_done, r_err, r_cs, r_both, r_post_valid, r_post_busy, r_timeout;
  logic [1:0] r_code;

  task automatic do_read(input logic sdhc, input logic [31:0] addr, input int poke_at);
    logic [7:0] exp;
    bit         fin;
    r_valid = 0; r_done = 0; r_err = 0; r_cs = 0; r_both = 0;
    r_post_valid = 0; r_post_busy = 0; r_timeout = 0; r_code = 2'b00;
    fin = 1'b0;
    @(negedge clk);
    is_sdhc  = sdhc;
    rd_addr  = addr;
    rd_start = 1'b1;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      rd_start = (poke_at != 0 && c == poke_at);
      if (poke_at != 0 && c == poke_at) begin
        rd_addr    = addr + 32'd1;
        init_ready = 1'b0;
      end
      if (dout_valid) begin
        r_valid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL dout_extra: got dout_valid with dout=%02h, required no more bytes", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin
            n_fail++;
            $display("FAIL dout_data[%0d]: got %02h, required %02h", r_valid - 1, dout, exp);
          end
          n_checks++;
          if (dout_last !== (exp_q.size() == 0)) begin
            n_fail++;
            $display("FAIL dout_last[%0d]: got %b, required %b", r_valid - 1, dout_last,
                     exp_q.size() == 0);
          end
        end
      end
      if (rd_done && rd_err) r_both++;
      if (rd_done || rd_err) begin
        r_done = rd_done;
        r_err  = rd_err;
        r_code = err_code;
        r_cs   = sd_cs_n;
        fin    = 1'b1;
      end
    end
    rd_start   = 1'b0;
    init_ready = 1'b1;
    if (!fin) r_timeout = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dout_valid) r_post_valid++;
      if (rd_busy) r_post_busy++;
    end
    n_checks++;
    if (r_timeout != 0 || r_both != 0 || r_post_valid != 0 || r_post_busy != 0) begin
      n_fail++;
      $display("FAIL read_wrapup: got timeout=%0d both=%0d post_valid=%0d post_busy=%0d, required all 0",
               r_timeout, r_both, r_post_valid, r_post_busy);
    end
    exp_q.delete();
  endtask

  task automatic check_cmd(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                           input logic [7:0] b5);
    logic [7:0] exp_cmd [6];
    exp_cmd = '{b0, b1, b2, b3, b4, b5};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (mosi_arr[i] !== exp_cmd[i]) begin
        n_fail++;
        $display("FAIL %s_cmd_byte%0d: got %02h, required %02h", name, i, mosi_arr[i], exp_cmd[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sd_cs_n, spi_bus.spi_start, spi_bus.spi_mosi} !== {1'b1, 1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_spi: got cs_n=%b start=%b mosi=%02h, required 1 0 ff",
               sd_cs_n, spi_bus.spi_start, spi_bus.spi_mosi);
    end
    n_checks++;
    if ({rd_busy, rd_done, rd_err, err_code} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b err=%b code=%b, required all 0",
               rd_busy, rd_done, rd_err, err_code);
    end
    n_checks++;
    if ({dout, dout_valid, dout_last} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_dout: got dout=%02h valid=%b last=%b, required 0",
               dout, dout_valid, dout_last);
    end
    n_checks++;
    if (spi_bus.spi_div !== 16'd2) begin
      n_fail++;
      $display("FAIL spi_div: got %0d, required 2", spi_bus.spi_div);
    end
    rst = 1'b0;
    init_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_sector();
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i % 256));
  endtask

  task automatic check_ok(input string name, input int starts_exp);
    n_checks++;
    if (r_done !== 1 || r_err !== 0 || r_cs !== 1 || r_valid !== 512) begin
      n_fail++;
      $display("FAIL %s_result: got done=%0d err=%0d cs_n=%0d valid=%0d, required 1 0 1 512",
               name, r_done, r_err, r_cs, r_valid);
    end
    n_checks++;
    if (n_starts !== starts_exp || dbl_starts !== 0) begin
      n_fail++;
      $display("FAIL %s_starts: got %0d (double %0d), required %0d (double 0)",
               name, n_starts, dbl_starts, starts_exp);
    end
  endtask

  task automatic check_err(input string name, input logic [1:0] code, input int starts_exp);
    n_checks++;
    if (r_done !== 0 || r_err !== 1 || r_code !== code || r_cs !== 1 || r_valid !== 0) begin
      n_fail++;
      $display("FAIL %s_result: got done=%0d err=%0d code=%b cs_n=%0d valid=%0d, required 0 1 %b 1 0",
               name, r_done, r_err, r_code, r_cs, r_valid, code);
    end
    n_checks++;
    if (err_code !== code || n_starts !== starts_exp) begin
      n_fail++;
      $display("FAIL %s_hold: got held code=%b starts=%0d, required %b %0d",
               name, err_code, n_starts, code, starts_exp);
    end
  endtask

  task automatic test_sdhc_read();
    sc_r1_delay = 2; sc_r1_val = 8'h00; sc_tok_delay = 3; sc_tok_val = 8'hFE;
    push_sector();
    do_read(1'b1, 32'd5, 0);
    check_cmd("sdhc", 8'h51, 8'h00, 8'h00, 8'h00, 8'h05, 8'h01);
    check_ok("sdhc", 6 + 3 + 4 + 512 + 2 + 1);
  endtask

  task automatic test_sdsc_addr();
    sc_r1_delay = 0; sc_r1_val = 8'h00; sc_tok_delay = 0; sc_tok_val = 8'hFE;
    push_sector();
    do_read(1'b0, 32'd5, 0);
    check_cmd("sdsc", 8'h51, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h01);
    check_ok("sdsc", 6 + 1 + 1 + 512 + 2 + 1);
  endtask

  task automatic test_r1_timeout();
    sc_r1_delay = 100; sc_r1_val = 8'h00;
    do_read(1'b1, 32'd7, 0);
    check_err("r1_timeout", 2'b01, 6 + 16 + 1);
  endtask

  task automatic test_r1_bad();
    sc_r1_delay = 0; sc_r1_val = 8'h04;
    do_read(1'b1, 32'd7, 0);
    check_err("r1_bad", 2'b10, 6 + 1 + 1);
  endtask

  task automatic test_token_err();
    sc_r1_delay = 0; sc_r1_val = 8'h00; sc_tok_delay = 1; sc_tok_val = 8'h08;
    do_read(1'b1, 32'd7, 0);
    check_err("token_err", 2'b11, 6 + 1 + 2 + 1);
  endtask

  // rd_start while busy and init_ready dropping mid-read must not disturb the read.
  task automatic test_ignore_busy();
    sc_r1_delay = 2; sc_r1_val = 8'h00; sc_tok_delay = 3; sc_tok_val = 8'hFE;
    push_sector();
    do_read(1'b1, 32'h0001_0203, 50);
    check_cmd("busy_poke", 8'h51, 8'h00, 8'h01, 8'h02, 8'h03, 8'h01);
    check_ok("busy_poke", 6 + 3 + 4 + 512 + 2 + 1);
  endtask

  task automatic test_not_ready();
    int starts_seen = 0;
    int busy_seen = 0;
    @(negedge clk);
    init_ready = 1'b0;
    rd_start   = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (spi_bus.spi_start) starts_seen++;
      if (rd_busy || !sd_cs_n) busy_seen++;
      @(negedge clk);
    end
    init_ready = 1'b1;
    n_checks++;
    if (starts_seen != 0 || busy_seen != 0) begin
      n_fail++;
      $display("FAIL not_ready_ignored: got starts=%0d busy_cycles=%0d, required 0 0",
               starts_seen, busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    int  seen = 0;
    int  after = 0;
    bit  hit = 1'b0;
    sc_r1_delay = 1; sc_r1_val = 8'h00; sc_tok_delay = 0; sc_tok_val = 8'hFE;
    @(negedge clk);
    is_sdhc  = 1'b1;
    rd_addr  = 32'd9;
    rd_start = 1'b1;
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk);
      rd_start = 1'b0;
      if (dout_valid) seen++;
      if (seen == 100) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got %0d data bytes, required 100", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({sd_cs_n, spi_bus.spi_start, spi_bus.spi_mosi, rd_busy, rd_done, rd_err, err_code,
         dout, dout_valid, dout_last} !== {1'b1, 1'b0, 8'hFF, 3'b000, 2'b00, 8'h00, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got cs_n=%b start=%b mosi=%02h busy=%b done=%b err=%b code=%b dout=%02h v=%b l=%b",
               sd_cs_n, spi_bus.spi_start, spi_bus.spi_mosi, rd_busy, rd_done, rd_err,
               err_code, dout, dout_valid, dout_last);
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rd_done || rd_err || rd_busy || dout_valid || !sd_cs_n) after++;
    end
    n_checks++;
    if (after != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d active cycles after reset, required 0", after);
    end
  endtask

  initial begin
    test_reset();
    test_sdhc_read();
    test_sdsc_addr();
    test_r1_timeout();
    test_r1_bad();
    test_token_err();
    test_ignore_busy();
    test_not_ready();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
